// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types shared by the UART transmit path (uart_tx_feeder, uart_send) and the
// planned receiver: the byte type and the feeder handshake state encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

   // One UART payload byte.
   typedef logic [7:0] byte_t;

   // Feeder handshake states towards uart_send.
   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,  // waiting for a byte and an idle transmitter
      S_STROBE = 2'd1,  // DATA_READY pulse cycle
      S_HOLD   = 2'd2,  // byte held, waiting for the transmitter to go busy
      S_BUSY   = 2'd3   // transmitter busy with the byte
   } tx_state_e;

   // Value driven on the data bus out of reset.
   localparam byte_t BYTE_RESET = 8'h00;

endpackage : uart_pkg

// File: rtl/uart_tx_feeder_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Single-clock synchronous byte FIFO with show-ahead head output.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push/wr_data write one byte (ignored while full)
//   pop          drop the head byte (ignored while empty)
//   head         current head byte, valid whenever empty is low
//   full, empty  registered occupancy flags
//   level        registered byte count, 0..DEPTH
// -----------------------------------------------------------------------------
module byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  byte_t                    wr_data,
   input  logic                     pop,
   output byte_t                    head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
   localparam logic [LW-1:0] LVL_ONE   = LW'(1'b1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_EMPTY = {LW{1'b0}};

   byte_t           mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [LW-1:0]   level_r;
   logic [LW-1:0]   level_nxt_s;
   logic            full_r;
   logic            empty_r;
   logic            push_s;
   logic            pop_s;

   // Full/empty come from the registered count, so a pop in the same cycle
   // never makes room for a write that arrived while full.
   assign push_s = push & ~full_r;
   assign pop_s  = pop & ~empty_r;

   // Next occupancy count from the qualified push/pop pair.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Pointers, count and flags; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= LVL_EMPTY;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r <= level_nxt_s;
         full_r  <= (level_nxt_s == LVL_FULL);
         empty_r <= (level_nxt_s == LVL_EMPTY);
      end
   end

   // Storage array; contents are only observed through a non-empty head.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = full_r;
   assign empty = empty_r;
   assign level = level_r;

endmodule : byte_fifo

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Buffers producer bytes and hands them one at a time to uart_send using its
// DATA / DATA_READY / IDLE handshake. A byte leaves the FIFO only once the
// transmitter has acknowledged it by dropping IDLE; if no acknowledge arrives
// within BUSY_TIMEOUT cycles the same byte is strobed again.
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   WR_DATA, WR_EN     producer write port
//   FULL, LEVEL        FIFO occupancy (registered)
//   OVERFLOW, CLR_OVF  sticky dropped-write flag and its clear
//   TX_DATA, TX_READY  byte and one-cycle strobe to uart_send
//   TX_IDLE            idle indication from uart_send (same clock domain)
// -----------------------------------------------------------------------------
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 64
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [7:0]               WR_DATA,
   input  logic                     WR_EN,
   output logic                     FULL,
   output logic [$clog2(DEPTH):0]   LEVEL,
   output logic                     OVERFLOW,
   input  logic                     CLR_OVF,
   output logic [7:0]               TX_DATA,
   output logic                     TX_READY,
   input  logic                     TX_IDLE
);

   localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   tx_state_e          state_r;
   tx_state_e          state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nxt_s;
   byte_t              tx_data_r;
   byte_t              tx_data_nxt_s;
   logic               tx_ready_r;
   logic               tx_ready_nxt_s;
   logic               ovf_r;
   logic               fifo_pop_s;
   byte_t              fifo_head_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (RST_N),
      .push    (WR_EN),
      .wr_data (WR_DATA),
      .pop     (fifo_pop_s),
      .head    (fifo_head_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .level   (LEVEL)
   );

   // Handshake next-state logic. TX_READY is registered, so it is asserted
   // for exactly the cycle spent in S_STROBE.
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      tx_data_nxt_s  = tx_data_r;
      tx_ready_nxt_s = 1'b0;
      fifo_pop_s     = 1'b0;
      case (state_r)
         S_WAIT: begin
            if (!fifo_empty_s && TX_IDLE) begin
               tx_data_nxt_s  = fifo_head_s;
               tx_ready_nxt_s = 1'b1;
               state_nxt_s    = S_STROBE;
            end else begin
               state_nxt_s    = S_WAIT;
            end
         end
         S_STROBE: begin
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = S_HOLD;
         end
         S_HOLD: begin
            // Acknowledge takes priority over the timeout in the same cycle.
            if (!TX_IDLE) begin
               fifo_pop_s  = 1'b1;
               state_nxt_s = S_BUSY;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = S_WAIT;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         S_BUSY: begin
            if (TX_IDLE) begin
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_BUSY;
            end
         end
         default: begin
            state_nxt_s = S_WAIT;
         end
      endcase
   end

   // Handshake state, timeout counter and registered transmitter outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r    <= S_WAIT;
         cnt_r      <= CNT_ZERO;
         tx_data_r  <= BYTE_RESET;
         tx_ready_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         tx_data_r  <= tx_data_nxt_s;
         tx_ready_r <= tx_ready_nxt_s;
      end
   end

   // Sticky overflow: a dropped write beats a simultaneous clear.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ovf_r <= 1'b0;
      end else if (WR_EN && fifo_full_s) begin
         ovf_r <= 1'b1;
      end else if (CLR_OVF) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign FULL     = fifo_full_s;
   assign OVERFLOW = ovf_r;
   assign TX_DATA  = tx_data_r;
   assign TX_READY = tx_ready_r;

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
// Directed scenarios plus a randomized traffic phase. A transaction-level
// model (byte queue, sticky flag and handshake timestamps) predicts LEVEL,
// FULL, OVERFLOW, TX_READY and TX_DATA on every cycle; a few literal
// expectations pin the model. A simple transmitter stand-in drives TX_IDLE.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int BT    = 64;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic            CLK = 1'b0;
   logic            RST_N = 1'b0;
   logic [7:0]      WR_DATA = 8'h00;
   logic            WR_EN = 1'b0;
   logic            CLR_OVF = 1'b0;
   logic            TX_IDLE = 1'b1;
   logic            FULL;
   logic            OVERFLOW;
   logic            TX_READY;
   logic [LW-1:0]   LEVEL;
   logic [7:0]      TX_DATA;

   uart_tx_feeder #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
      .CLK(CLK), .RST_N(RST_N), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
      .FULL(FULL), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF),
      .TX_DATA(TX_DATA), .TX_READY(TX_READY), .TX_IDLE(TX_IDLE)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Serial frame as put on TXD: start bit, data LSB first, stop bit.
   function automatic logic [9:0] frame_of(input logic [7:0] d);
      logic [9:0] f;
      f[9] = 1'b0;
      for (int i = 0; i < 8; i++) f[8-i] = d[i];
      f[0] = 1'b1;
      return f;
   endfunction

   // ---------------- behavioural reference model ----------------
   logic [7:0] mq[$];        // bytes the feeder must still deliver, in order
   bit         m_ovf = 1'b0;
   bit         m_pend = 1'b0; // a strobe is due this cycle
   bit         m_await = 1'b0;// strobed byte not yet acknowledged
   bit         m_busy = 1'b0; // acknowledged, transmitter not idle again yet
   int         m_cyc = 0;
   int         m_wait_from = 0;
   int         m_strobe_at = 0;
   int         m_ack_at = 0;
   logic [7:0] m_byte = 8'h00;

   always @(negedge CLK) begin : model
      int  sz;
      bit  full0;
      if (!RST_N) begin
         mq.delete();
         m_ovf = 1'b0; m_pend = 1'b0; m_await = 1'b0; m_busy = 1'b0;
         m_wait_from = m_cyc + 1;
      end else begin
         sz = mq.size();
         full0 = (sz == DEPTH);
         chk("level", 32'(LEVEL), 32'(sz));
         chk("full", 32'(FULL), 32'(full0));
         chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
         chk("tx_ready", 32'(TX_READY), 32'(m_pend));
         if (m_pend) begin
            if (sz > 0) begin
               chk("strobe_data", 32'(TX_DATA), 32'(mq[0]));
               m_byte = mq[0];
            end
            m_await = 1'b1;
            m_strobe_at = m_cyc;
         end else if (m_await) begin
            chk("hold_data", 32'(TX_DATA), 32'(m_byte));
            if (TX_IDLE == 1'b0) begin
               if (sz > 0) void'(mq.pop_front());
               m_await = 1'b0; m_busy = 1'b1; m_ack_at = m_cyc;
            end else if (m_cyc == m_strobe_at + BT) begin
               m_await = 1'b0; m_wait_from = m_cyc + 1;
            end
         end else if (m_busy) begin
            if (m_cyc == m_ack_at + 1) chk("post_ack_data", 32'(TX_DATA), 32'(m_byte));
            if (TX_IDLE == 1'b1) begin
               m_busy = 1'b0; m_wait_from = m_cyc + 1;
            end
         end
         if (WR_EN == 1'b1) begin
            if (full0) m_ovf = 1'b1;
            else mq.push_back(WR_DATA);
         end
         if (!(WR_EN == 1'b1 && full0) && CLR_OVF == 1'b1) m_ovf = 1'b0;
         m_pend = !m_await && !m_busy && (m_cyc >= m_wait_from) && (sz != 0) && (TX_IDLE == 1'b1);
      end
      m_cyc++;
   end

   // ---------------- stimulus / transmitter stand-in ----------------
   int drv_cyc = 0;
   int tx_mode = 1;      // 0 auto responder, 1 idle high, 2 idle low, 3 manual
   int resp_pct = 100;
   int drop_at = -1;
   int busy_left = 0;
   logic [7:0] tx_log[$];

   task automatic set_mode(input int m);
      tx_mode = m; drop_at = -1; busy_left = 0;
   endtask

   task automatic tick();
      @(posedge CLK); #1;
      drv_cyc++;
      WR_EN = 1'b0; CLR_OVF = 1'b0;
      case (tx_mode)
         0: begin
            if (busy_left > 0) begin
               TX_IDLE = 1'b0; busy_left--;
            end else if (drop_at == drv_cyc) begin
               TX_IDLE = 1'b0; tx_log.push_back(TX_DATA);
               busy_left = int'($urandom_range(0, 3)); drop_at = -1;
            end else begin
               TX_IDLE = 1'b1;
               if (TX_READY === 1'b1 && drop_at < 0 && int'($urandom_range(1, 100)) <= resp_pct)
                  drop_at = drv_cyc + 1 + int'($urandom_range(0, 4));
            end
         end
         1: TX_IDLE = 1'b1;
         2: TX_IDLE = 1'b0;
         default: ;
      endcase
   endtask

   task automatic drain(input string name);
      int n = 0;
      set_mode(0); resp_pct = 100;
      tick();
      while ((LEVEL !== '0 || busy_left > 0 || drop_at >= 0 || TX_IDLE !== 1'b1) && n < 4000) begin
         tick(); n++;
      end
      chk(name, 32'(n < 4000), 32'd1);
      repeat (3) tick();
   endtask

   initial begin : watchdog
      #3000000;
      failures++;
      $display("FAIL watchdog: actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int st[$];
      int i, n, bad;

      // Reset values while RST_N is low.
      repeat (3) tick();
      @(negedge CLK);
      chk("rst_tx_ready", 32'(TX_READY), 32'd0);
      chk("rst_tx_data", 32'(TX_DATA), 32'h00);
      chk("rst_level", 32'(LEVEL), 32'd0);
      chk("rst_full", 32'(FULL), 32'd0);
      chk("rst_overflow", 32'(OVERFLOW), 32'd0);
      tick(); RST_N = 1'b1;
      repeat (2) tick();

      // Single byte: strobe two cycles after the write.
      set_mode(3); TX_IDLE = 1'b1;
      tick(); WR_EN = 1'b1; WR_DATA = 8'hAA;
      tick(); @(negedge CLK);
      chk("single_early", 32'(TX_READY), 32'd0);
      tick(); @(negedge CLK);
      chk("single_ready", 32'(TX_READY), 32'd1);
      chk("single_data", 32'(TX_DATA), 32'hAA);
      chk("single_frame", 32'(frame_of(TX_DATA)), 32'(10'b0010101011));
      tick(); TX_IDLE = 1'b0;
      tick(); TX_IDLE = 1'b1; @(negedge CLK);
      chk("single_popped", 32'(LEVEL), 32'd0);
      repeat (3) tick();

      // Burst of three bytes.
      set_mode(1);
      tick(); WR_EN = 1'b1; WR_DATA = 8'hAA; @(negedge CLK);
      tick(); WR_EN = 1'b1; WR_DATA = 8'h4C; @(negedge CLK);
      chk("burst_lvl1", 32'(LEVEL), 32'd1);
      tick(); WR_EN = 1'b1; WR_DATA = 8'h00; @(negedge CLK);
      chk("burst_lvl2", 32'(LEVEL), 32'd2);
      tick(); @(negedge CLK);
      chk("burst_lvl3", 32'(LEVEL), 32'd3);
      tx_log.delete();
      drain("burst_drain");
      chk("burst_count", 32'(tx_log.size()), 32'd3);
      if (tx_log.size() == 3) begin
         chk("burst_b0", 32'(tx_log[0]), 32'hAA);
         chk("burst_b1", 32'(tx_log[1]), 32'h4C);
         chk("burst_b2", 32'(tx_log[2]), 32'h00);
      end

      // Overflow with the transmitter stuck busy.
      set_mode(2);
      for (int k = 0; k <= DEPTH; k++) begin
         tick(); WR_EN = 1'b1; WR_DATA = 8'(8'h80 + k);
      end
      tick(); @(negedge CLK);
      chk("ovf_full", 32'(FULL), 32'd1);
      chk("ovf_level", 32'(LEVEL), 32'(DEPTH));
      chk("ovf_flag", 32'(OVERFLOW), 32'd1);
      tick(); CLR_OVF = 1'b1;
      tick(); @(negedge CLK);
      chk("ovf_cleared", 32'(OVERFLOW), 32'd0);
      tick(); CLR_OVF = 1'b1; WR_EN = 1'b1; WR_DATA = 8'hEE;
      tick(); @(negedge CLK);
      chk("ovf_set_wins", 32'(OVERFLOW), 32'd1);
      tick(); CLR_OVF = 1'b1;
      tx_log.delete();
      drain("ovf_drain");
      chk("ovf_count", 32'(tx_log.size()), 32'(DEPTH));
      bad = 0;
      foreach (tx_log[k]) if (tx_log[k] !== 8'(8'h80 + k)) bad++;
      chk("ovf_order", 32'(bad), 32'd0);

      // Timeout: transmitter never acknowledges.
      set_mode(1);
      tick(); WR_EN = 1'b1; WR_DATA = 8'h5A;
      n = 0;
      while (st.size() < 2 && n < 400) begin
         tick(); n++;
         if (TX_READY === 1'b1) begin
            st.push_back(drv_cyc);
            chk("tmo_data", 32'(TX_DATA), 32'h5A);
            chk("tmo_level", 32'(LEVEL), 32'd1);
         end
      end
      chk("tmo_seen", 32'(st.size()), 32'd2);
      if (st.size() == 2) chk("tmo_period", 32'(st[1] - st[0]), 32'(BT + 2));
      drain("tmo_drain");

      // Simultaneous write and pop at LEVEL=3.
      set_mode(3); TX_IDLE = 1'b1;
      tick(); WR_EN = 1'b1; WR_DATA = 8'h11;
      tick(); WR_EN = 1'b1; WR_DATA = 8'h22;
      tick(); WR_EN = 1'b1; WR_DATA = 8'h33;
      tick(); TX_IDLE = 1'b0; WR_EN = 1'b1; WR_DATA = 8'h44; @(negedge CLK);
      chk("simul_pre", 32'(LEVEL), 32'd3);
      tick(); TX_IDLE = 1'b1; @(negedge CLK);
      chk("simul_post", 32'(LEVEL), 32'd3);
      drain("simul_drain");

      // Wrap-around: 3*DEPTH bytes through the FIFO.
      tx_log.delete();
      i = 0; n = 0;
      while (i < 3 * DEPTH && n < 6000) begin
         tick(); n++;
         if (FULL !== 1'b1) begin
            WR_EN = 1'b1; WR_DATA = 8'(i); i++;
         end
      end
      drain("wrap_drain");
      chk("wrap_count", 32'(tx_log.size()), 32'(3 * DEPTH));
      bad = 0;
      foreach (tx_log[k]) if (tx_log[k] !== 8'(k)) bad++;
      chk("wrap_order", 32'(bad), 32'd0);

      // Reset during S_HOLD acts without a clock edge.
      set_mode(3); TX_IDLE = 1'b1;
      tick(); WR_EN = 1'b1; WR_DATA = 8'h33;
      tick(); tick(); tick();
      #1 RST_N = 1'b0;
      #1;
      chk("arst_tx_ready", 32'(TX_READY), 32'd0);
      chk("arst_tx_data", 32'(TX_DATA), 32'h00);
      chk("arst_level", 32'(LEVEL), 32'd0);
      tick(); tick(); RST_N = 1'b1;
      repeat (2) tick();

      // Randomized traffic.
      set_mode(0); resp_pct = 75;
      repeat (3000) begin
         tick();
         if ($urandom_range(0, 99) < 35) begin
            WR_EN = 1'b1; WR_DATA = 8'($urandom);
         end
         if ($urandom_range(0, 99) < 3) CLR_OVF = 1'b1;
      end
      drain("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_tx_feeder

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-buffering feeder directly upstream of `uart_send`. Producers in the camera pipeline write bytes at CLK rate into an internal FIFO. The feeder presents one byte at a time to `uart_send` through its DATA/DATA_READY/IDLE handshake and holds the byte stable until the transmitter has accepted it. It keeps bursty pixel/register traffic from being lost while the serial link drains at baud rate.

## Interface
Parameters:
- DEPTH, 16: FIFO depth in bytes; power of two, ≥2.
- BUSY_TIMEOUT, 64: CLK cycles to wait in S_HOLD for TX_IDLE to fall before re-strobing. Must exceed one UART_CLK tick period.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- WR_DATA  in  8  byte from producer.
- WR_EN  in  1  write strobe, one byte per high cycle.
- FULL  out  1  FIFO holds DEPTH bytes.
- LEVEL  out  $clog2(DEPTH)+1  bytes currently stored.
- OVERFLOW  out  1  sticky; set when WR_EN is high while FULL.
- CLR_OVF  in  1  clears OVERFLOW.
- TX_DATA  out  8  to `uart_send` DATA.
- TX_READY  out  1  to `uart_send` DATA_READY; single-cycle pulse.
- TX_IDLE  in  1  from `uart_send` IDLE; same CLK domain, no synchroniser.

## Operation
- FSM states: S_WAIT, S_STROBE, S_HOLD, S_BUSY.
- S_WAIT: when LEVEL≠0 and TX_IDLE=1, latch the FIFO head into TX_DATA and go to S_STROBE.
- S_STROBE: TX_READY=1 for exactly this cycle. Clear the timeout counter. Go to S_HOLD.
- S_HOLD: TX_DATA is held.
  - If TX_IDLE=0: pop the FIFO head and go to S_BUSY.
  - Otherwise, if the counter reaches BUSY_TIMEOUT-1: go to S_WAIT without popping. The same byte is re-strobed.
- S_BUSY: TX_DATA is held. When TX_IDLE=1, go to S_WAIT.
- A byte is removed from the FIFO only after the transmitter acknowledges it by dropping TX_IDLE. Bytes are never lost or duplicated on a normal handshake.
- Write while FULL: the byte is dropped and OVERFLOW is set. FULL is evaluated at the start of the cycle, so a pop in the same cycle does not admit the write.
- Write and pop in the same cycle when not full: both take effect and LEVEL is unchanged.
- CLR_OVF and an overflowing write in the same cycle: OVERFLOW stays 1 (set wins).
- Pointers are log2(DEPTH) bits and wrap naturally. LEVEL is kept as a separate counter, 0..DEPTH.

## Timing
- Reset values: TX_READY=0, TX_DATA=8'h00, FULL=0, LEVEL=0, OVERFLOW=0, state S_WAIT, pointers 0.
- Reset assertion mid-transfer discards FIFO contents and any in-flight byte immediately. The pulse or hold is abandoned, and the downstream transmitter is reset by the same RST_N.
- Latency: WR_EN in cycle 0 into an empty FIFO, with TX_IDLE=1 → TX_READY high in cycle 2, with TX_DATA valid in that same cycle.
- TX_DATA is stable from the TX_READY cycle until the cycle after TX_IDLE is seen low.
- After TX_IDLE returns high, the next TX_READY comes no earlier than 2 cycles later.
- FULL and LEVEL update on the clock edge after the write or pop.

## Structure
- Shared package `uart_pkg`: the state enum (S_WAIT..S_BUSY) and a byte typedef, shared with `uart_send` and a future receiver.
- Sub-module `byte_fifo`: synchronous single-clock FIFO with DEPTH parameter, push/pop/full/empty/level, and show-ahead head output.
- The top level contains the FSM, timeout counter and overflow flag.

## Test plan
- Single byte: write 8'hAA into an empty FIFO with TX_IDLE=1 → TX_READY pulses in cycle 2 with TX_DATA=8'hAA. With the `uart_send` model attached, the TXD frame is 0,0,1,0,1,0,1,0,1,1.
- Burst: write 8'hAA, 8'h4C, 8'h00 back-to-back → three TX_READY pulses, each issued only after IDLE has returned high. TX_DATA follows the same order, and LEVEL goes 1,2,3 then drains to 0.
- Overflow: with TX_IDLE held 0, write DEPTH+1 bytes → FULL=1 and LEVEL=DEPTH. OVERFLOW=1 after the extra write, and that extra byte never appears on TX_DATA. Pulse CLR_OVF → OVERFLOW=0.
- Timeout: hold TX_IDLE=1 forever → TX_READY re-pulses every BUSY_TIMEOUT+2 cycles with the same TX_DATA, and LEVEL does not decrease.
- Simultaneous write and pop at LEVEL=3 → LEVEL stays 3. Wrap-around: push and pop 3×DEPTH bytes (values 0..47) → output order is intact.
- Reset mid-transfer: assert RST_N=0 during S_HOLD → TX_READY=0, TX_DATA=8'h00 and LEVEL=0 immediately, without waiting for a clock edge.
